// File: rtl/mau_pkg.sv
// Shared types for the memory access sequencer: FSM states, access kinds, reset instruction.
package mau_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2
  } kind_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch beats store beats load; load is what remains when neither is asserted.
  function automatic kind_e pick_kind(input logic fetch, input logic store);
    if (fetch) return KIND_FETCH;
    if (store) return KIND_STORE;
    return KIND_LOAD;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Shared instruction/data memory bus: registered request, one-cycle ack with read data.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mau_timer.sv
// Bus timeout counter: counts enabled cycles since the last clear.
// expired_o marks the TIMEOUT-th consecutive enabled cycle.
module mau_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && !expired_o) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired_o = en_i && (count_q == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Sequences fetch/load/store intents into req/ack bus transactions and latches results.
// stall is held while a request is outstanding; misaligned or timed-out accesses park in FAULT.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] RESET_INSTR = NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic               load_req,
  input  logic               store_req,
  input  logic [31:0]        addr,
  input  logic [31:0]        pc_in,
  input  logic [31:0]        wdata,
  output logic               stall,
  output logic [31:0]        instr,
  output logic [31:0]        old_pc,
  output logic [31:0]        data,
  output logic               fault,
  mem_access_unit_if.master  mem
);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [31:0] pc_q, instr_q, old_pc_q, data_q, mem_addr_q, mem_wdata_q;
  logic        mem_req_q, mem_we_q, fault_q;
  logic        req, aligned, start, capture, timed_out, enter_fault;
  logic        tmr_clr, tmr_en, expired;

  assign req     = fetch_req | load_req | store_req;
  assign aligned = (addr[1:0] == 2'b00);
  assign kind_d  = pick_kind(fetch_req, store_req);

  mau_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req) state_d = aligned ? ST_BUSY : ST_FAULT;
      ST_BUSY: begin
        // An ack in the expiry cycle still completes the access.
        if (mem.mem_ack)  state_d = ST_DONE;
        else if (expired) state_d = ST_FAULT;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall       = req && (state_q != ST_DONE);
    start       = (state_q == ST_IDLE) && req && aligned;
    capture     = (state_q == ST_BUSY) && mem.mem_ack;
    timed_out   = (state_q == ST_BUSY) && !mem.mem_ack && expired;
    enter_fault = (state_q != ST_FAULT) && (state_d == ST_FAULT);
    tmr_clr     = (state_q != ST_BUSY);
    tmr_en      = (state_q == ST_BUSY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      kind_q      <= KIND_FETCH;
      pc_q        <= '0;
      instr_q     <= RESET_INSTR;
      old_pc_q    <= '0;
      data_q      <= '0;
      fault_q     <= 1'b0;
    end else begin
      if (start) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= (kind_d == KIND_STORE);
        mem_addr_q  <= addr;
        mem_wdata_q <= wdata;
        kind_q      <= kind_d;
        pc_q        <= pc_in;
      end
      if (capture) begin
        if (kind_q == KIND_FETCH) begin
          instr_q  <= mem.mem_rdata;
          old_pc_q <= pc_q;
        end
        if (kind_q == KIND_LOAD) begin
          data_q <= mem.mem_rdata;
        end
      end
      if (capture || timed_out) begin
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
      end
      if (enter_fault) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign instr         = instr_q;
  assign old_pc        = old_pc_q;
  assign data          = data_q;
  assign fault         = fault_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access sequencer between the multicycle controller/datapath and a single shared instruction/data memory that has variable latency. It takes the controller's per-state memory intents (fetch, load, store) and runs a registered req/ack transaction for each. It latches the fetched instruction plus its PC, or the loaded word, and holds `stall` high until the access completes. It also detects misaligned addresses and bus timeouts.

## Interface
- `TIMEOUT`, 255: maximum BUSY cycles without `mem_ack` before a fault.
- `RESET_INSTR`, 32'h0000_0013: reset value of `instr` (addi x0,x0,0).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `fetch_req` in 1: controller in fetch state (its IRWrite).
- `load_req` in 1: controller in memory-read state.
- `store_req` in 1: controller in memory-write state (its MemWrite).
- `addr` in 32: byte address from the Adr mux (PC or ALU result).
- `pc_in` in 32: current PC, captured with the instruction.
- `wdata` in 32: store data.
- `stall` out 1: controller and datapath hold all register/PC/state enables while this is high.
- `instr` out 32: instruction register.
- `old_pc` out 32: PC of `instr`.
- `data` out 32: load data register.
- `fault` out 1: sticky misalign/timeout error.
- `mem_req` out 1: bus request, registered.
- `mem_we` out 1: write strobe, valid with `mem_req`.
- `mem_addr` out 32: registered address.
- `mem_wdata` out 32: registered write data.
- `mem_rdata` in 32: read data, valid with `mem_ack`.
- `mem_ack` in 1: one-cycle completion pulse.

## Operation
- Request = `fetch_req | load_req | store_req`. Priority when more than one is asserted: fetch > store > load. Only the winner is performed.
- Request inputs are levels. The controller holds them for as long as `stall` is high.
- States: IDLE, BUSY, DONE, FAULT.
- IDLE with a request and `addr[1:0]==0`:
  - Register `addr` and `wdata` into `mem_addr` and `mem_wdata`.
  - Set `mem_we` for a store.
  - Latch the request kind and `pc_in`.
  - Set `mem_req`=1 and move to BUSY.
- IDLE with a request and `addr[1:0]!=0`: move to FAULT. No bus cycle is issued.
- BUSY: `mem_req` stays at 1 and the timeout counter increments.
  - On `mem_ack`:
    - Fetch: `instr`<=`mem_rdata`, `old_pc`<=latched PC.
    - Load: `data`<=`mem_rdata`.
    - Store: nothing is captured.
    - Then `mem_req`<=0, `mem_we`<=0, and move to DONE.
  - If the counter reaches `TIMEOUT` with no ack: `mem_req`<=0, `mem_we`<=0, move to FAULT.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally. A request present in DONE is not started until the following IDLE cycle.
- FAULT: `fault`=1 and `stall`=1 for as long as a request is present. Only `reset` exits this state.
- `stall` is combinational: request present AND state != DONE. With no request, `stall`=0.
- `mem_ack` is ignored outside BUSY.
- If the request is withdrawn during BUSY, the transaction still completes with the latched kind.

## Timing
- All outputs reset asynchronously as follows:
  - `mem_req`, `mem_we`, `fault` = 0.
  - `mem_addr`, `mem_wdata`, `data`, `old_pc` = 0.
  - `instr` = `RESET_INSTR`.
  - State = IDLE, counter = 0.
- Cycle 0: request seen in IDLE. Cycle 1: `mem_req` high. Ack in cycle k≥1 sets DONE in cycle k+1, where `stall` is low. The controller advances on the edge that ends DONE.
- Zero-wait memory (ack in the first `mem_req` cycle) gives 3 cycles per access. Each wait state adds 1.
- `instr`, `old_pc` and `data` are valid from DONE onward and hold until the next capture.
- Counter width is clog2(`TIMEOUT`+1). It clears on entry to BUSY. The timeout fires on the cycle in which the count equals `TIMEOUT`. An ack arriving in that same cycle wins.
- Reset asserted mid-BUSY drops `mem_req` immediately (asynchronously). No capture takes place.

## Structure
- Package `mau_pkg`:
  - State enum (IDLE/BUSY/DONE/FAULT).
  - Request-kind enum (FETCH/LOAD/STORE).
  - `NOP_INSTR` constant.
- Sub-module `mau_timer`: the timeout counter, with clear/enable inputs and an `expired` output, parameterised by `TIMEOUT`.
- Integration: the controller ANDs its PCWrite, RegWrite and state-register enable with `!stall`.

## Test plan
- Fetch: addr=0x100, pc_in=0x100, ack in the 1st req cycle with rdata=0x00500093 -> `instr`=0x00500093, `old_pc`=0x100, `stall` low exactly 3 cycles after the request is raised.
- Load at 0x2004 with 3 wait states, rdata=0xDEADBEEF -> `data`=0xDEADBEEF, `stall` high 5 cycles, `instr` unchanged.
- Store at 0x2008, wdata=0x12345678 -> `mem_we`=1, `mem_addr`=0x2008, `mem_wdata`=0x12345678 while `mem_req`=1, then `mem_we`=0; `instr` and `data` unchanged.
- Load at 0x2002 -> no `mem_req`, `fault`=1, `stall` stays high; `reset` low clears both.
- TIMEOUT=4, no ack -> `mem_req` drops after 4 BUSY cycles and `fault`=1. Separately: fetch+load asserted together -> only the fetch is performed.
- Reset asserted in the 2nd BUSY cycle -> `mem_req`=0 immediately, `instr`=0x00000013, state IDLE after reset is released.
